// File: rtl/video_pattern_gen.sv
// Video test-pattern generator.
// Takes de/hsync/vsync from a timing generator and produces {r,g,b} pixels.
// The syncs come out with the same one-cycle latency as the pixels.
// Mode and solid colour are latched on the vsync rising edge, so a frame
// never changes pattern partway through.
module video_pattern_gen #(
  parameter int BPC         = 8,
  parameter int H_ACTIVE    = 1920,
  parameter int CHECK_SHIFT = 5,
  parameter int GRID_SHIFT  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             de,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [2:0]       mode,
  input  logic [3*BPC-1:0] solid_color,
  output logic [3*BPC-1:0] data_o,
  output logic             de_o,
  output logic             hsync_o,
  output logic             vsync_o
);

  localparam int W     = 3 * BPC;
  localparam int BAR_W = H_ACTIVE / 8;

  logic           de_d, vsync_d, hsync_d;
  logic           vs_rise, de_fall;
  logic [15:0]    x, y;
  logic [BPC-1:0] frame;
  logic [2:0]     mode_r;
  logic [W-1:0]   color_r;
  logic [W-1:0]   pixel;
  logic [W-1:0]   data_r;
  logic [15:0]    bar_q;
  logic [2:0]     bar_idx;
  logic [BPC-1:0] sum_r, sum_g, sum_b;

  assign vs_rise = vsync & ~vsync_d;
  assign de_fall = de_d & ~de;

  // Delayed copies of the timing inputs; these double as the sync outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_d    <= 1'b0;
      vsync_d <= 1'b0;
      hsync_d <= 1'b0;
    end else begin
      de_d    <= de;
      vsync_d <= vsync;
      hsync_d <= hsync;
    end
  end

  // Pixel position and frame counters. A vsync clear takes priority over a line step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x     <= '0;
      y     <= '0;
      frame <= '0;
    end else begin
      x <= de ? x + 16'd1 : 16'd0;
      if (vs_rise)      y <= '0;
      else if (de_fall) y <= y + 16'd1;
      if (vs_rise) frame <= frame + 1'b1;
    end
  end

  // Latch the configuration only at frame start, so frames never tear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r  <= '0;
      color_r <= '0;
    end else if (vs_rise) begin
      mode_r  <= mode;
      color_r <= solid_color;
    end
  end

  // Bar index saturates at 7 (black) for columns beyond the active width.
  assign bar_q   = x / 16'(BAR_W);
  assign bar_idx = (bar_q > 16'd7) ? 3'd7 : bar_q[2:0];

  assign sum_r = x[BPC-1:0] + frame;
  assign sum_g = y[BPC-1:0] + frame;
  assign sum_b = x[BPC-1:0] + y[BPC-1:0];

  // Pattern selection from the pre-update counter and latch values.
  always_comb begin
    pixel = '0;
    case (mode_r)
      3'd0: pixel = color_r;
      // Bar order white,yellow,cyan,green,magenta,red,blue,black maps to
      // r = ~idx[1], g = ~idx[2], b = ~idx[0].
      3'd1: pixel = {{BPC{~bar_idx[1]}}, {BPC{~bar_idx[2]}}, {BPC{~bar_idx[0]}}};
      3'd2: pixel = {3{x[BPC-1:0]}};
      3'd3: if (x[CHECK_SHIFT] ^ y[CHECK_SHIFT]) pixel = '1;
      3'd4: pixel = {sum_r, sum_g, sum_b};
      3'd5: if (x[GRID_SHIFT-1:0] == '0 || y[GRID_SHIFT-1:0] == '0) pixel = '1;
      default: pixel = '0;
    endcase
  end

  // Output pixel register. Blanking forces black.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_r <= '0;
    else     data_r <= de ? pixel : '0;
  end

  assign data_o  = data_r;
  assign de_o    = de_d;
  assign hsync_o = hsync_d;
  assign vsync_o = vsync_d;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed testbench for video_pattern_gen (BPC=8, H_ACTIVE=64, CHECK_SHIFT=3).
module tb_video_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        de, hsync, vsync;
  logic [2:0]  mode;
  logic [23:0] solid_color;
  logic [23:0] data_o;
  logic        de_o, hsync_o, vsync_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] px  [0:63];
  logic        deo [0:63];
  logic        pre_deo;

  video_pattern_gen #(
    .BPC(8), .H_ACTIVE(64), .CHECK_SHIFT(3), .GRID_SHIFT(6)
  ) dut (
    .clk(clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync),
    .mode(mode), .solid_color(solid_color),
    .data_o(data_o), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample just after the rising edge.
  task automatic step(input logic d, input logic h, input logic v);
    @(negedge clk);
    de = d; hsync = h; vsync = v;
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
  endtask

  task automatic run_line(input int n);
    step(0, 1, 0);
    step(0, 0, 0);
    pre_deo = de_o;
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0);
      px[i]  = data_o;
      deo[i] = de_o;
    end
    step(0, 0, 0);
  endtask

  task automatic check_bars(input string pfx);
    check_val({pfx, "_px0"},  px[0],  24'hFFFFFF);
    check_val({pfx, "_px7"},  px[7],  24'hFFFFFF);
    check_val({pfx, "_px8"},  px[8],  24'hFFFF00);
    check_val({pfx, "_px16"}, px[16], 24'h00FFFF);
    check_val({pfx, "_px24"}, px[24], 24'h00FF00);
    check_val({pfx, "_px32"}, px[32], 24'hFF00FF);
    check_val({pfx, "_px40"}, px[40], 24'hFF0000);
    check_val({pfx, "_px48"}, px[48], 24'h0000FF);
    check_val({pfx, "_px56"}, px[56], 24'h000000);
    check_val({pfx, "_px63"}, px[63], 24'h000000);
  endtask

  initial begin
    rst = 1'b1; de = 0; hsync = 0; vsync = 0; mode = 3'd1; solid_color = 24'hABCDEF;

    // Reset held with toggling inputs: everything stays zero.
    for (int i = 0; i < 4; i++) begin
      step(1'(i), 1'(i + 1), 1);
      mode = 3'(i + 1);
      check_val("reset_outs", {data_o, de_o, hsync_o, vsync_o}, 28'h0);
    end
    @(negedge clk);
    vsync = 0; de = 0; rst = 1'b0;

    // Before any vsync rise the output is black even during active video.
    run_line(8);
    check_val("pre_vs_black", px[3], 24'h0);

    // Colour bars with latency check.
    mode = 3'd1;
    step(0, 0, 1);
    check_val("vsync_o_dly", vsync_o, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    check_val("vsync_o_low", vsync_o, 0);
    run_line(64);
    check_val("de_o_before", pre_deo, 0);
    check_val("de_o_first", deo[0], 1);
    check_val("de_o_last", deo[63], 1);
    check_bars("bars");
    check_val("blank_black", data_o, 24'h0);
    check_val("de_o_fall", de_o, 0);

    // Checkerboard, three lines of 16 pixels: y stays below 8.
    mode = 3'd3;
    vs_pulse();
    for (int ln = 0; ln < 3; ln++) begin
      run_line(16);
      for (int i = 0; i < 16; i++)
        check_val($sformatf("chk_y%0d_x%0d", ln, i), px[i], (i >= 8) ? 24'hFFFFFF : 24'h0);
    end

    // Mode change mid-frame is ignored until the next vsync rise.
    mode = 3'd2;
    run_line(16);
    check_val("latch_hold_x0", px[0], 24'h000000);
    check_val("latch_hold_x8", px[8], 24'hFFFFFF);
    vs_pulse();
    run_line(16);
    check_val("ramp_x0", px[0], 24'h000000);
    check_val("ramp_x1", px[1], 24'h010101);
    check_val("ramp_x15", px[15], 24'h0F0F0F);

    // Scrolling gradient from a freshly reset frame counter.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    mode = 3'd4;
    vs_pulse();
    run_line(4);
    check_val("scroll_f1_x0", px[0], 24'h010100);
    check_val("scroll_f1_x1", px[1], 24'h020101);
    vs_pulse();
    run_line(4);
    check_val("scroll_f2_x0", px[0], 24'h020200);
    vs_pulse();
    run_line(4);
    check_val("scroll_f3_x0", px[0], 24'h030300);
    run_line(4);
    check_val("scroll_f3_y1_x0", px[0], 24'h030401);

    // Solid colour.
    mode = 3'd0; solid_color = 24'h123456;
    vs_pulse();
    solid_color = 24'h654321;
    run_line(8);
    check_val("solid_x3", px[3], 24'h123456);

    // Grid: row 0 all white, later rows white only on column 0.
    mode = 3'd5;
    vs_pulse();
    run_line(16);
    check_val("grid_y0_x5", px[5], 24'hFFFFFF);
    run_line(16);
    check_val("grid_y1_x0", px[0], 24'hFFFFFF);
    check_val("grid_y1_x5", px[5], 24'h000000);

    // Reserved mode is black.
    mode = 3'd6;
    vs_pulse();
    run_line(8);
    check_val("mode6_black", px[0], 24'h0);

    // Asynchronous reset in the middle of a colour-bar line.
    mode = 3'd1;
    vs_pulse();
    step(0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    check_val("async_pre_data", data_o, 24'hFFFF00);
    #2 rst = 1'b1;
    #1;
    check_val("async_data", data_o, 24'h0);
    check_val("async_de", de_o, 0);
    @(negedge clk);
    de = 0; rst = 1'b0;
    run_line(16);
    check_val("post_rst_black", px[8], 24'h0);
    vs_pulse();
    run_line(64);
    check_bars("bars2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
